// File: rtl/simple_issue_sched_if.sv
// Dispatch, CDB and issue signal bundle for simple_issue_sched.
// The master side drives dispatch, CDB, stall and flush; the slave side is the scheduler.
interface simple_issue_sched_if;
   logic        disp_valid;
   logic [80:0] disp_inst;
   logic [3:0]  disp_rob_num;
   logic        disp_ready;
   logic        cdb_valid;
   logic [3:0]  cdb_rob_num;
   logic [31:0] cdb_data;
   logic        issue_stall;
   logic        flush;
   logic        issue_valid;
   logic [80:0] issue_inst;
   logic [3:0]  issue_rob_num;
   logic [2:0]  occupancy;

   modport master (
      output disp_valid, disp_inst, disp_rob_num, cdb_valid, cdb_rob_num, cdb_data,
             issue_stall, flush,
      input  disp_ready, issue_valid, issue_inst, issue_rob_num, occupancy
   );

   modport slave (
      input  disp_valid, disp_inst, disp_rob_num, cdb_valid, cdb_rob_num, cdb_data,
             issue_stall, flush,
      output disp_ready, issue_valid, issue_inst, issue_rob_num, occupancy
   );
endinterface

// File: rtl/simple_issue_sched.sv
// Four-entry issue queue for the simple FU with CDB wakeup and single issue per cycle.
// Define SIMPLE_SCHED_AGE_EN to select the oldest ready entry instead of the lowest index.
module simple_issue_sched (
   input  logic                 clk,
   input  logic                 rst,
   simple_issue_sched_if.slave  bus
);
   localparam int unsigned NENT = 4;

   logic [NENT-1:0] ent_valid;
   logic [80:0]     ent_inst [NENT];
   logic [3:0]      ent_rob  [NENT];
`ifdef SIMPLE_SCHED_AGE_EN
   logic [1:0]      ent_age  [NENT];
   logic [1:0]      age_nxt  [NENT];
   logic [1:0]      sel_age;
`endif

   logic [NENT-1:0] ready;
   logic [NENT-1:0] valid_nxt;
   logic            sel_found, free_found;
   logic [1:0]      sel_idx, free_idx;
   logic            issue_fire, disp_fire;
   logic [80:0]     disp_woke;
   logic [2:0]      occ, occ_nxt;
   logic            iss_valid;
   logic [80:0]     iss_inst;
   logic [3:0]      iss_rob;

   assign bus.occupancy     = occ;
   assign bus.disp_ready    = (occ < 3'd4);
   assign bus.issue_valid   = iss_valid;
   assign bus.issue_inst    = iss_inst;
   assign bus.issue_rob_num = iss_rob;

   assign issue_fire = sel_found & ~bus.issue_stall;
   assign disp_fire  = bus.disp_valid & bus.disp_ready & free_found;

   always_comb begin
      sel_found  = 1'b0;
      sel_idx    = '0;
      free_found = 1'b0;
      free_idx   = '0;
`ifdef SIMPLE_SCHED_AGE_EN
      sel_age    = '0;
`endif
      for (int unsigned i = 0; i < NENT; i++) begin
         ready[i] = ent_valid[i] & ent_inst[i][38] & ent_inst[i][5];
`ifdef SIMPLE_SCHED_AGE_EN
         if (ready[i] && (!sel_found || ent_age[i] > sel_age)) begin
            sel_found = 1'b1;
            sel_idx   = 2'(i);
            sel_age   = ent_age[i];
         end
`else
         if (ready[i] && !sel_found) begin
            sel_found = 1'b1;
            sel_idx   = 2'(i);
         end
`endif
         if (!ent_valid[i] && !free_found) begin
            free_found = 1'b1;
            free_idx   = 2'(i);
         end
      end
   end

   // An instruction dispatched alongside a matching broadcast is stored already woken.
   always_comb begin
      disp_woke = bus.disp_inst;
      if (bus.cdb_valid && !bus.disp_inst[5] && bus.disp_inst[9:6] == bus.cdb_rob_num) begin
         disp_woke[37:6] = bus.cdb_data;
         disp_woke[5]    = 1'b1;
      end
      if (bus.cdb_valid && !bus.disp_inst[38] && bus.disp_inst[42:39] == bus.cdb_rob_num) begin
         disp_woke[70:39] = bus.cdb_data;
         disp_woke[38]    = 1'b1;
      end
   end

   always_comb begin
      valid_nxt = ent_valid;
      if (issue_fire) valid_nxt[sel_idx] = 1'b0;
      if (disp_fire)  valid_nxt[free_idx] = 1'b1;
      occ_nxt = '0;
      for (int unsigned i = 0; i < NENT; i++) occ_nxt = occ_nxt + 3'(valid_nxt[i]);
   end

`ifdef SIMPLE_SCHED_AGE_EN
   // Age counts the valid entries younger than this one, so ages stay unique in 0..3.
   always_comb begin
      for (int unsigned i = 0; i < NENT; i++) begin
         age_nxt[i] = ent_age[i];
         if (ent_valid[i]) begin
            age_nxt[i] = ent_age[i] + 2'(disp_fire)
                         - 2'(issue_fire && ent_age[i] > ent_age[sel_idx]);
         end
         if (disp_fire && free_idx == 2'(i)) age_nxt[i] = '0;
      end
   end
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         ent_valid <= '0;
         occ       <= '0;
         iss_valid <= 1'b0;
         iss_inst  <= '0;
         iss_rob   <= '0;
`ifdef SIMPLE_SCHED_AGE_EN
         for (int unsigned i = 0; i < NENT; i++) ent_age[i] <= '0;
`endif
      end else if (bus.flush) begin
         ent_valid <= '0;
         occ       <= '0;
         iss_valid <= 1'b0;
`ifdef SIMPLE_SCHED_AGE_EN
         for (int unsigned i = 0; i < NENT; i++) ent_age[i] <= '0;
`endif
      end else begin
         for (int unsigned i = 0; i < NENT; i++) begin
            if (ent_valid[i] && bus.cdb_valid && !ent_inst[i][5] &&
                ent_inst[i][9:6] == bus.cdb_rob_num) begin
               ent_inst[i][37:6] <= bus.cdb_data;
               ent_inst[i][5]    <= 1'b1;
            end
            if (ent_valid[i] && bus.cdb_valid && !ent_inst[i][38] &&
                ent_inst[i][42:39] == bus.cdb_rob_num) begin
               ent_inst[i][70:39] <= bus.cdb_data;
               ent_inst[i][38]    <= 1'b1;
            end
`ifdef SIMPLE_SCHED_AGE_EN
            ent_age[i] <= age_nxt[i];
`endif
         end
         if (disp_fire) begin
            ent_inst[free_idx] <= disp_woke;
            ent_rob[free_idx]  <= bus.disp_rob_num;
         end
         ent_valid <= valid_nxt;
         occ       <= occ_nxt;
         if (!bus.issue_stall) begin
            iss_valid <= sel_found;
            if (sel_found) begin
               iss_inst <= ent_inst[sel_idx];
               iss_rob  <= ent_rob[sel_idx];
            end
         end
      end
   end
endmodule

// File: tb/tb_simple_issue_sched.sv
// Directed self-checking bench for simple_issue_sched; expectations follow SIMPLE_SCHED_AGE_EN.
module tb_simple_issue_sched;
   logic clk;
   logic rst;
   int   checks;
   int   failures;

   simple_issue_sched_if bus();

   simple_issue_sched dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [80:0] mk(input logic [4:0] aluop, input logic s1v,
                                      input logic [31:0] s1, input logic s2v,
                                      input logic [31:0] s2, input logic [4:0] rd);
      return {aluop, 5'b00001, s2, s2v, s1, s1v, rd};
   endfunction

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [80:0] obs, input logic [80:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic disp(input logic v, input logic [80:0] inst, input logic [3:0] rob);
      bus.disp_valid   = v;
      bus.disp_inst    = inst;
      bus.disp_rob_num = rob;
   endtask

   task automatic cdb(input logic v, input logic [3:0] tag, input logic [31:0] data);
      bus.cdb_valid   = v;
      bus.cdb_rob_num = tag;
      bus.cdb_data    = data;
   endtask

   logic [80:0] inst_a, inst_e2, inst_s2w;
   logic [3:0]  first_rob, second_rob;

   initial begin
      checks = 0;
      failures = 0;
      rst = 1'b1;
      disp(1'b0, '0, '0);
      cdb(1'b0, '0, '0);
      bus.issue_stall = 1'b0;
      bus.flush       = 1'b0;

      // Reset state
      cyc(); cyc();
      chk("rst_issue_valid", 81'(bus.issue_valid), 81'(0));
      chk("rst_occupancy",   81'(bus.occupancy), 81'(0));
      chk("rst_disp_ready",  81'(bus.disp_ready), 81'(1));
      chk("rst_issue_rob",   81'(bus.issue_rob_num), 81'(0));
      chk("rst_issue_inst",  bus.issue_inst, 81'(0));
      rst = 1'b0;

      // Single ready instruction: issue two edges after dispatch
      inst_a = mk(5'd0, 1'b1, 32'd5, 1'b1, 32'd7, 5'd1);
      disp(1'b1, inst_a, 4'd3);
      cyc();
      disp(1'b0, '0, '0);
      chk("basic_occ_after_disp", 81'(bus.occupancy), 81'(1));
      chk("basic_not_yet_valid",  81'(bus.issue_valid), 81'(0));
      cyc();
      chk("basic_issue_valid", 81'(bus.issue_valid), 81'(1));
      chk("basic_issue_rob",   81'(bus.issue_rob_num), 81'(3));
      chk("basic_issue_inst",  bus.issue_inst, inst_a);
      chk("basic_occ_zero",    81'(bus.occupancy), 81'(0));
      cyc();
      chk("basic_valid_drops", 81'(bus.issue_valid), 81'(0));

      // Fill all four entries with waiting instructions
      disp(1'b1, mk(5'd1, 1'b0, 32'hB, 1'b1, 32'h21, 5'd2), 4'd4); cyc();
      disp(1'b1, mk(5'd1, 1'b0, 32'hC, 1'b1, 32'h21, 5'd2), 4'd5); cyc();
      inst_e2 = mk(5'd2, 1'b0, 32'hA, 1'b1, 32'h22, 5'd3);
      disp(1'b1, inst_e2, 4'd6); cyc();
      chk("fill_occ3_ready", 81'(bus.disp_ready), 81'(1));
      disp(1'b1, mk(5'd1, 1'b0, 32'hD, 1'b1, 32'h21, 5'd2), 4'd7); cyc();
      chk("full_disp_ready", 81'(bus.disp_ready), 81'(0));
      chk("full_occupancy",  81'(bus.occupancy), 81'(4));
      disp(1'b1, mk(5'd3, 1'b1, 32'h1, 1'b1, 32'h2, 5'd4), 4'd8); cyc();
      disp(1'b0, '0, '0);
      chk("full_5th_ignored_occ",   81'(bus.occupancy), 81'(4));
      chk("full_5th_ignored_issue", 81'(bus.issue_valid), 81'(0));
      cdb(1'b1, 4'd10, 32'h1234);
      cyc();
      cdb(1'b0, '0, '0);
      chk("wake_not_same_cycle", 81'(bus.issue_valid), 81'(0));
      cyc();
      chk("wake_issue_valid", 81'(bus.issue_valid), 81'(1));
      chk("wake_issue_rob",   81'(bus.issue_rob_num), 81'(6));
      chk("wake_issue_inst",  bus.issue_inst, mk(5'd2, 1'b1, 32'h1234, 1'b1, 32'h22, 5'd3));
      chk("wake_occ3",        81'(bus.occupancy), 81'(3));
      bus.flush = 1'b1;
      cyc();
      bus.flush = 1'b0;
      chk("flush_clears_occ", 81'(bus.occupancy), 81'(0));

      // Dispatch coinciding with the matching broadcast
      disp(1'b1, mk(5'd4, 1'b1, 32'h11, 1'b0, 32'h9, 5'd5), 4'd2);
      cdb(1'b1, 4'd9, 32'hABCD);
      cyc();
      disp(1'b0, '0, '0);
      cdb(1'b0, '0, '0);
      cyc();
      inst_s2w = mk(5'd4, 1'b1, 32'h11, 1'b1, 32'hABCD, 5'd5);
      chk("dispwake_issue_valid", 81'(bus.issue_valid), 81'(1));
      chk("dispwake_issue_rob",   81'(bus.issue_rob_num), 81'(2));
      chk("dispwake_issue_inst",  bus.issue_inst, inst_s2w);
      cyc();

      // Selection policy: older rob 2 in entry1 versus newer rob 5 in entry0
      bus.issue_stall = 1'b1;
      disp(1'b1, mk(5'd5, 1'b0, 32'hE, 1'b1, 32'h1, 5'd6), 4'd1); cyc();
      disp(1'b1, mk(5'd5, 1'b1, 32'h2, 1'b1, 32'h3, 5'd7), 4'd2); cyc();
      disp(1'b0, '0, '0);
      cdb(1'b1, 4'd14, 32'h55); cyc();
      cdb(1'b0, '0, '0);
      bus.issue_stall = 1'b0;
      cyc();
      chk("age_first_rob1", 81'(bus.issue_rob_num), 81'(1));
      bus.issue_stall = 1'b1;
      disp(1'b1, mk(5'd6, 1'b1, 32'h4, 1'b1, 32'h5, 5'd8), 4'd5); cyc();
      chk("age_stall_hold_rob", 81'(bus.issue_rob_num), 81'(1));
      chk("age_occ2",           81'(bus.occupancy), 81'(2));
      disp(1'b0, '0, '0);
      bus.issue_stall = 1'b0;
`ifdef SIMPLE_SCHED_AGE_EN
      first_rob = 4'd2; second_rob = 4'd5;
`else
      first_rob = 4'd5; second_rob = 4'd2;
`endif
      cyc();
      chk("policy_first",  81'(bus.issue_rob_num), 81'(first_rob));
      cyc();
      chk("policy_second", 81'(bus.issue_rob_num), 81'(second_rob));
      cyc();
      chk("policy_drain_valid", 81'(bus.issue_valid), 81'(0));
      chk("policy_drain_occ",   81'(bus.occupancy), 81'(0));

      // Stall holds issue registers for three cycles
      disp(1'b1, mk(5'd7, 1'b1, 32'h10, 1'b1, 32'h20, 5'd9), 4'd10); cyc();
      disp(1'b1, mk(5'd7, 1'b1, 32'h11, 1'b1, 32'h21, 5'd9), 4'd11); cyc();
      chk("disp_issue_same_occ", 81'(bus.occupancy), 81'(1));
      chk("stall_pre_rob",       81'(bus.issue_rob_num), 81'(10));
      inst_a = bus.issue_inst;
      bus.issue_stall = 1'b1;
      disp(1'b1, mk(5'd7, 1'b1, 32'h12, 1'b1, 32'h22, 5'd9), 4'd12); cyc();
      disp(1'b0, '0, '0);
      for (int k = 0; k < 2; k++) begin
         chk("stall_valid_hold", 81'(bus.issue_valid), 81'(1));
         chk("stall_rob_hold",   81'(bus.issue_rob_num), 81'(10));
         chk("stall_inst_hold",  bus.issue_inst, mk(5'd7, 1'b1, 32'h10, 1'b1, 32'h20, 5'd9));
         chk("stall_occ_hold",   81'(bus.occupancy), 81'(2));
         cyc();
      end
      chk("stall_rob_hold3", 81'(bus.issue_rob_num), 81'(10));
      chk("stall_occ_hold3", 81'(bus.occupancy), 81'(2));
      bus.issue_stall = 1'b0;
`ifdef SIMPLE_SCHED_AGE_EN
      first_rob = 4'd11; second_rob = 4'd12;
`else
      first_rob = 4'd12; second_rob = 4'd11;
`endif
      cyc();
      chk("release_first", 81'(bus.issue_rob_num), 81'(first_rob));
      chk("release_occ1",  81'(bus.occupancy), 81'(1));
      cyc();
      chk("release_second", 81'(bus.issue_rob_num), 81'(second_rob));
      chk("release_valid",  81'(bus.issue_valid), 81'(1));
      chk("release_occ0",   81'(bus.occupancy), 81'(0));
      cyc();

      // Flush beats dispatch and issue
      bus.issue_stall = 1'b1;
      disp(1'b1, mk(5'd8, 1'b1, 32'h1, 1'b1, 32'h2, 5'd1), 4'd3); cyc();
      disp(1'b1, mk(5'd8, 1'b1, 32'h3, 1'b1, 32'h4, 5'd1), 4'd4); cyc();
      bus.issue_stall = 1'b0;
      bus.flush = 1'b1;
      disp(1'b1, mk(5'd8, 1'b1, 32'h5, 1'b1, 32'h6, 5'd1), 4'd6); cyc();
      bus.flush = 1'b0;
      disp(1'b0, '0, '0);
      chk("flush_occ",        81'(bus.occupancy), 81'(0));
      chk("flush_issue_valid", 81'(bus.issue_valid), 81'(0));
      chk("flush_disp_ready", 81'(bus.disp_ready), 81'(1));
      cyc();
      chk("flush_disp_absent", 81'(bus.issue_valid), 81'(0));
      chk("flush_occ_stays",   81'(bus.occupancy), 81'(0));

      // Reset dominates flush and clears the issue registers
      disp(1'b1, mk(5'd9, 1'b1, 32'h7, 1'b1, 32'h8, 5'd2), 4'd9); cyc();
      disp(1'b0, '0, '0); cyc();
      chk("pre_rst_issue_rob", 81'(bus.issue_rob_num), 81'(9));
      rst = 1'b1;
      bus.flush = 1'b1;
      cyc();
      rst = 1'b0;
      bus.flush = 1'b0;
      chk("rst_flush_inst", bus.issue_inst, 81'(0));
      chk("rst_flush_rob",  81'(bus.issue_rob_num), 81'(0));
      chk("rst_flush_occ",  81'(bus.occupancy), 81'(0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
